load_store_queue: RTL

Parametrised load/store queue between the decoder/reservation stations and the memory controller. It is the successor of the in-order load/store buffer. It holds `DEPTH` memory operations in program order and captures operands from two broadcast buses. Loads may issue ahead of older stores whose addresses are resolved and non-conflicting, while stores issue strictly in order at ROB commit. Results go to the ROB and onto the broadcast bus.

---
 rtl/load_store_queue.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_queue.sv
// Load/store queue: DEPTH entries in program order, out-of-order load issue past resolved
// non-conflicting stores, in-order store issue at commit. Optional LSQ_STORE_FORWARD_EN.
module load_store_queue #(
  parameter int DEPTH     = 16,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  output logic                 mc_en,
  output logic [31:0]          mc_addr,
  output logic [3:0]           mc_type,
  output logic [31:0]          mc_write_data,
  input  logic                 mc_rdy,
  input  logic [31:0]          mc_read_data,
  output logic                 dec_full,
  input  logic                 dec_rdy,
  input  logic [3:0]           dec_type,
  input  logic [31:0]          dec_data_j,
  input  logic [31:0]          dec_data_k,
  input  logic                 dec_pending_j,
  input  logic                 dec_pending_k,
  input  logic [ROB_WIDTH-1:0] dec_dependency_j,
  input  logic [ROB_WIDTH-1:0] dec_dependency_k,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [31:0]          dec_imm,
  input  logic                 rs_broadcast_en,
  input  logic [ROB_WIDTH-1:0] rs_broadcast_rob_id,
  input  logic [31:0]          rs_broadcast_data,
  input  logic                 lsb_broadcast_en,
  input  logic [ROB_WIDTH-1:0] lsb_broadcast_rob_id,
  input  logic [31:0]          lsb_broadcast_data,
  output logic                 rob_rdy,
  output logic [ROB_WIDTH-1:0] rob_rob_id,
  output logic [31:0]          rob_data,
  output logic                 broadcast_en,
  output logic [ROB_WIDTH-1:0] broadcast_rob_id,
  output logic [31:0]          broadcast_data,
  input  logic                 commit_info_empty,
  input  logic [ROB_WIDTH-1:0] commit_info_current_rob_id
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]                r_present, r_issued, r_done;
  logic [DEPTH-1:0]                r_pend_j, r_pend_k, r_addr_valid;
  logic [DEPTH-1:0][3:0]           r_type;
  logic [DEPTH-1:0][31:0]          r_data_j, r_data_k, r_imm, r_addr;
  logic [DEPTH-1:0][ROB_WIDTH-1:0] r_dep_j, r_dep_k, r_rob;
  logic [AW-1:0]                   r_head, r_tail;
  logic [CW-1:0]                   r_count;

  // in-flight memory request; r_discard marks one orphaned by a flush
  logic                 r_busy, r_discard, r_inf_store;
  logic [AW-1:0]        r_inf_idx;
  logic [ROB_WIDTH-1:0] r_inf_rob;

  logic                 r_fwd_valid;
  logic [AW-1:0]        r_fwd_idx;
  logic [ROB_WIDTH-1:0] r_fwd_rob;
  logic [31:0]          r_fwd_data;

  logic          w_mc_done, w_mc_report, w_fwd_out, w_retire, w_insert, w_can_sel;
  logic          w_st_sel, w_ld_sel, w_ld_fwd;
  logic [AW-1:0] w_ld_idx;
  logic [31:0]   w_ld_fdata;

  assign dec_full    = (r_count == CW'(DEPTH));
  assign w_mc_done   = rdy_in & r_busy & mc_rdy;
  assign w_mc_report = w_mc_done & (r_inf_store | (~r_discard & ~flush));
  assign w_fwd_out   = rdy_in & r_fwd_valid & ~w_mc_done & ~flush;
  assign w_retire    = r_present[r_head] & r_done[r_head];
  assign w_insert    = dec_rdy & ~dec_full & ~flush;
  assign w_can_sel   = ~r_busy & ~r_fwd_valid;

  assign rob_rdy    = w_mc_report | w_fwd_out;
  assign rob_rob_id = w_mc_report ? r_inf_rob :
                      w_fwd_out   ? r_fwd_rob : '0;
  assign rob_data   = w_mc_report ? (r_inf_store ? 32'd0 : mc_read_data) :
                      w_fwd_out   ? r_fwd_data : 32'd0;
  assign broadcast_en     = rob_rdy;
  assign broadcast_rob_id = rob_rob_id;
  assign broadcast_data   = rob_data;

`ifdef LSQ_STORE_FORWARD_EN
  function automatic logic [31:0] fwd_ext(input logic [31:0] d, input logic [3:0] t);
    case (t[1:0])
      2'b00:   return t[2] ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   return t[2] ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction
`endif

  // store at head needs the ROB to be committing exactly this tag
  assign w_st_sel = r_present[r_head] & ~r_done[r_head] & ~r_issued[r_head] &
                    r_type[r_head][3] & ~r_pend_j[r_head] & ~r_pend_k[r_head] &
                    r_addr_valid[r_head] & ~commit_info_empty &
                    (commit_info_current_rob_id == r_rob[r_head]);

  always_comb begin
    logic [AW-1:0] li, oj;
    logic          ok, conf;
`ifdef LSQ_STORE_FORWARD_EN
    logic [AW-1:0] cj;
    cj = '0;
`endif
    li = '0; oj = '0; ok = 1'b0; conf = 1'b0;
    w_ld_sel = 1'b0; w_ld_idx = '0; w_ld_fwd = 1'b0; w_ld_fdata = '0;
    for (int a = 0; a < DEPTH; a++) begin
      li = r_head + AW'(a);
      ok = 1'b1; conf = 1'b0;
      // walk older entries oldest-first so the last hit is the youngest conflicting store
      for (int b = 0; b < a; b++) begin
        oj = r_head + AW'(b);
        if (r_present[oj] && !r_done[oj]) begin
          if (!r_type[oj][3] || !r_addr_valid[oj]) ok = 1'b0;
          else if (r_addr[oj][31:2] == r_addr[li][31:2]) begin
            conf = 1'b1;
`ifdef LSQ_STORE_FORWARD_EN
            cj = oj;
`endif
          end
        end
      end
      if (!w_ld_sel && r_present[li] && !r_issued[li] && !r_done[li] &&
          !r_type[li][3] && r_addr_valid[li] && ok) begin
        if (!conf) begin
          w_ld_sel = 1'b1;
          w_ld_idx = li;
        end
`ifdef LSQ_STORE_FORWARD_EN
        else if (r_addr[cj] == r_addr[li] && r_type[cj][1:0] >= r_type[li][1:0] &&
                 !r_pend_k[cj]) begin
          w_ld_sel   = 1'b1;
          w_ld_idx   = li;
          w_ld_fwd   = 1'b1;
          w_ld_fdata = fwd_ext(r_data_k[cj], r_type[li]);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_present <= '0; r_issued <= '0; r_done <= '0;
      r_pend_j <= '0; r_pend_k <= '0; r_addr_valid <= '0;
      r_type <= '0; r_data_j <= '0; r_data_k <= '0; r_imm <= '0; r_addr <= '0;
      r_dep_j <= '0; r_dep_k <= '0; r_rob <= '0;
      r_head <= '0; r_tail <= '0; r_count <= '0;
      r_busy <= 1'b0; r_discard <= 1'b0; r_inf_store <= 1'b0;
      r_inf_idx <= '0; r_inf_rob <= '0;
      r_fwd_valid <= 1'b0; r_fwd_idx <= '0; r_fwd_rob <= '0; r_fwd_data <= '0;
      mc_en <= 1'b0; mc_addr <= '0; mc_type <= '0; mc_write_data <= '0;
    end else if (rdy_in) begin
      if (w_mc_done) begin
        r_busy    <= 1'b0;
        r_discard <= 1'b0;
        mc_en     <= 1'b0;
      end
      if (w_fwd_out) r_fwd_valid <= 1'b0;
      if (flush) begin
        r_present <= '0; r_issued <= '0; r_done <= '0; r_addr_valid <= '0;
        r_head <= '0; r_tail <= '0; r_count <= '0;
        r_fwd_valid <= 1'b0;
        if (r_busy && !w_mc_done) r_discard <= 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_present[i] && r_pend_j[i]) begin
            if (rs_broadcast_en && rs_broadcast_rob_id == r_dep_j[i]) begin
              r_data_j[i] <= rs_broadcast_data; r_pend_j[i] <= 1'b0;
            end else if (lsb_broadcast_en && lsb_broadcast_rob_id == r_dep_j[i]) begin
              r_data_j[i] <= lsb_broadcast_data; r_pend_j[i] <= 1'b0;
            end
          end
          if (r_present[i] && r_pend_k[i]) begin
            if (rs_broadcast_en && rs_broadcast_rob_id == r_dep_k[i]) begin
              r_data_k[i] <= rs_broadcast_data; r_pend_k[i] <= 1'b0;
            end else if (lsb_broadcast_en && lsb_broadcast_rob_id == r_dep_k[i]) begin
              r_data_k[i] <= lsb_broadcast_data; r_pend_k[i] <= 1'b0;
            end
          end
          if (r_present[i] && !r_pend_j[i] && !r_addr_valid[i]) begin
            r_addr[i]       <= r_data_j[i] + r_imm[i];
            r_addr_valid[i] <= 1'b1;
          end
        end
        if (w_mc_done && !r_discard) r_done[r_inf_idx] <= 1'b1;
        if (w_fwd_out) r_done[r_fwd_idx] <= 1'b1;
        if (w_retire) begin
          r_present[r_head] <= 1'b0;
          r_head            <= r_head + 1'b1;
        end
        if (w_insert) begin
          r_present[r_tail]    <= 1'b1;
          r_issued[r_tail]     <= 1'b0;
          r_done[r_tail]       <= 1'b0;
          r_addr_valid[r_tail] <= 1'b0;
          r_type[r_tail]       <= dec_type;
          r_imm[r_tail]        <= dec_imm;
          r_rob[r_tail]        <= dec_rob_id;
          r_dep_j[r_tail]      <= dec_dependency_j;
          r_dep_k[r_tail]      <= dec_dependency_k;
          if (dec_pending_j && rs_broadcast_en && rs_broadcast_rob_id == dec_dependency_j) begin
            r_data_j[r_tail] <= rs_broadcast_data; r_pend_j[r_tail] <= 1'b0;
          end else if (dec_pending_j && lsb_broadcast_en && lsb_broadcast_rob_id == dec_dependency_j) begin
            r_data_j[r_tail] <= lsb_broadcast_data; r_pend_j[r_tail] <= 1'b0;
          end else begin
            r_data_j[r_tail] <= dec_data_j; r_pend_j[r_tail] <= dec_pending_j;
          end
          if (dec_pending_k && rs_broadcast_en && rs_broadcast_rob_id == dec_dependency_k) begin
            r_data_k[r_tail] <= rs_broadcast_data; r_pend_k[r_tail] <= 1'b0;
          end else if (dec_pending_k && lsb_broadcast_en && lsb_broadcast_rob_id == dec_dependency_k) begin
            r_data_k[r_tail] <= lsb_broadcast_data; r_pend_k[r_tail] <= 1'b0;
          end else begin
            r_data_k[r_tail] <= dec_data_k; r_pend_k[r_tail] <= dec_pending_k;
          end
          r_tail <= r_tail + 1'b1;
        end
        r_count <= r_count + CW'(w_insert) - CW'(w_retire);
        if (w_can_sel) begin
          if (w_st_sel) begin
            r_issued[r_head] <= 1'b1;
            r_busy <= 1'b1; r_inf_store <= 1'b1;
            r_inf_idx <= r_head; r_inf_rob <= r_rob[r_head];
            mc_en <= 1'b1; mc_addr <= r_addr[r_head];
            mc_type <= r_type[r_head]; mc_write_data <= r_data_k[r_head];
          end else if (w_ld_sel && w_ld_fwd) begin
            r_issued[w_ld_idx] <= 1'b1;
            r_fwd_valid <= 1'b1; r_fwd_idx <= w_ld_idx;
            r_fwd_rob <= r_rob[w_ld_idx]; r_fwd_data <= w_ld_fdata;
          end else if (w_ld_sel) begin
            r_issued[w_ld_idx] <= 1'b1;
            r_busy <= 1'b1; r_inf_store <= 1'b0;
            r_inf_idx <= w_ld_idx; r_inf_rob <= r_rob[w_ld_idx];
            mc_en <= 1'b1; mc_addr <= r_addr[w_ld_idx];
            mc_type <= r_type[w_ld_idx]; mc_write_data <= 32'd0;
          end
        end
      end
    end
  end
endmodule
